byte_unstriping_n: RTL and testbench

//  Parametrised successor of the 2-lane byte unstriper. It merges LANES striped byte lanes back

---
 rtl/byte_unstriping_n.sv | 85 ++++++++
 tb/tb_byte_unstriping_n.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/byte_unstriping_n.sv
// byte_unstriping_n: merges LANES striped lanes back into one word stream, strict round-robin,
// with a FIFO per lane and a single registered output slot.
module byte_unstriping_n #(
  parameter int LANES = 2,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(LANES),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk_2f,
  input  logic                   reset_L,
  input  logic [LANES*WIDTH-1:0] data_stripe,
  input  logic [LANES-1:0]       valid_stripe,
  output logic [LANES-1:0]       ready_stripe,
  output logic [WIDTH-1:0]       data_unstripe,
  output logic                   valid_unstripe,
  input  logic                   ready_unstripe,
  output logic [LW-1:0]          lane_unstripe,
  output logic                   overflow_err
);
  logic [WIDTH-1:0] mem_q [LANES][DEPTH];
  logic [LANES-1:0][PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LANES-1:0][CW-1:0] cnt_q, cnt_d;
  logic [LANES-1:0] rdy_q, rdy_d, push, pop;
  logic [LW-1:0] rr_q, rr_d, lane_q, lane_d;
  logic [WIDTH-1:0] data_q, data_d, head;
  logic valid_q, valid_d, ovf_q, ovf_d, slot_free, load;

  assign slot_free = !valid_q || ready_unstripe;
  assign load = slot_free && cnt_q[rr_q] != '0;
  assign head = mem_q[rr_q][rd_q[rr_q]];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      push[i] = valid_stripe[i] && rdy_q[i];
      pop[i] = load && rr_q == LW'(i);
      wr_d[i] = wr_q[i] + PW'(push[i]);
      rd_d[i] = rd_q[i] + PW'(pop[i]);
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      rdy_d[i] = cnt_d[i] != CW'(DEPTH);
    end
    // Ready is the registered start-of-cycle view, so a push into a full lane is lost even if it pops now.
    ovf_d = ovf_q || |(valid_stripe & ~rdy_q);
    rr_d = load ? (rr_q == LW'(LANES - 1) ? '0 : rr_q + LW'(1)) : rr_q;
    valid_d = slot_free ? load : valid_q;
    data_d = load ? head : data_q;
    lane_d = load ? rr_q : lane_q;
  end

  always_ff @(posedge clk_2f) begin
    for (int i = 0; i < LANES; i++)
      if (push[i]) mem_q[i][wr_q[i]] <= data_stripe[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      rdy_q <= '1;
      rr_q <= '0;
      data_q <= '0;
      lane_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      rr_q <= rr_d;
      data_q <= data_d;
      lane_q <= lane_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
    end
  end

  assign ready_stripe = rdy_q;
  assign data_unstripe = data_q;
  assign valid_unstripe = valid_q;
  assign lane_unstripe = lane_q;
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_byte_unstriping_n.sv
// tb_byte_unstriping_n: random + directed stimulus against a queue-based model; a monitor checks
// every output handshake against per-lane expected queues in round-robin order.
module tb_byte_unstriping_n;
  localparam int L = 3;
  localparam int W = 8;
  localparam int D = 4;
  localparam int LW = $clog2(L);

  logic clk = 1'b0;
  logic reset_L;
  logic [L*W-1:0] data_stripe;
  logic [L-1:0] valid_stripe, ready_stripe;
  logic [W-1:0] data_unstripe;
  logic valid_unstripe, ready_unstripe, overflow_err;
  logic [LW-1:0] lane_unstripe;

  int checks = 0;
  int fails = 0;

  logic [W-1:0] exp_q [L][$];
  logic [W-1:0] fq [L][$];
  logic m_v, m_ovf;
  logic [W-1:0] m_d;
  int m_l, m_rr;

  byte_unstriping_n #(.LANES(L), .WIDTH(W), .DEPTH(D)) dut (
    .clk_2f(clk),
    .reset_L(reset_L),
    .data_stripe(data_stripe),
    .valid_stripe(valid_stripe),
    .ready_stripe(ready_stripe),
    .data_unstripe(data_unstripe),
    .valid_unstripe(valid_unstripe),
    .ready_unstripe(ready_unstripe),
    .lane_unstripe(lane_unstripe),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic rst_n, input logic [L-1:0] vs, input logic [L*W-1:0] ds, input logic ru);
    logic [L-1:0] full;
    reset_L = rst_n;
    valid_stripe = vs;
    data_stripe = ds;
    ready_unstripe = ru;
    if (!rst_n) begin
      for (int i = 0; i < L; i++) begin
        fq[i].delete();
        exp_q[i].delete();
      end
      m_v = 1'b0;
      m_d = '0;
      m_l = 0;
      m_rr = 0;
      m_ovf = 1'b0;
    end else begin
      for (int i = 0; i < L; i++) full[i] = fq[i].size() == D;
      if (!m_v || ru) begin
        if (fq[m_rr].size() > 0) begin
          m_d = fq[m_rr].pop_front();
          m_l = m_rr;
          m_v = 1'b1;
          m_rr = (m_rr + 1) % L;
        end else m_v = 1'b0;
      end
      for (int i = 0; i < L; i++)
        if (vs[i]) begin
          if (full[i]) m_ovf = 1'b1;
          else begin
            fq[i].push_back(ds[i*W +: W]);
            exp_q[i].push_back(ds[i*W +: W]);
          end
        end
    end
    @(posedge clk);
    #2;
    check("valid", 32'(valid_unstripe), 32'(m_v));
    if (m_v) begin
      check("data", 32'(data_unstripe), 32'(m_d));
      check("lane", 32'(lane_unstripe), m_l);
    end else if (!rst_n) begin
      check("reset_data", 32'(data_unstripe), 0);
      check("reset_lane", 32'(lane_unstripe), 0);
    end
    for (int i = 0; i < L; i++) check($sformatf("ready%0d", i), 32'(ready_stripe[i]), 32'(fq[i].size() != D));
    check("overflow", 32'(overflow_err), 32'(m_ovf));
  endtask

  initial begin
    int n, ln;
    logic stall;
    logic [W-1:0] pd;
    logic [LW-1:0] pl;
    n = 0;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (stall) begin
        check("stall_data", 32'(data_unstripe), 32'(pd));
        check("stall_lane", 32'(lane_unstripe), 32'(pl));
      end
      if (!reset_L) n = 0;
      else if (valid_unstripe && ready_unstripe) begin
        ln = n % L;
        check("out_order_lane", 32'(lane_unstripe), ln);
        check("sb_nonempty", 32'(exp_q[ln].size() != 0), 1);
        if (exp_q[ln].size() != 0) check("out_data", 32'(data_unstripe), 32'(exp_q[ln].pop_front()));
        n++;
      end
      stall = reset_L && valid_unstripe && !ready_unstripe;
      pd = data_unstripe;
      pl = lane_unstripe;
    end
  end

  initial begin
    logic [L-1:0] vs;
    logic [L*W-1:0] ds;
    logic ru, rst_n;
    int vp, rp;
    step(0, '0, '0, 0);
    step(0, '0, '0, 0);
    for (int r = 0; r < 3; r++)
      step(1, '1, {W'(3*r+2), W'(3*r+1), W'(3*r)}, 1);
    repeat (3) step(1, '0, '0, 1);
    step(1, 3'b001, {8'h00, 8'h00, 8'hA0}, 1);
    step(1, 3'b001, {8'h00, 8'h00, 8'hA3}, 1);
    repeat (3) step(1, '0, '0, 1);
    step(1, 3'b010, {8'h00, 8'hA1, 8'h00}, 1);
    step(1, 3'b100, {8'hA2, 8'h00, 8'h00}, 1);
    repeat (2) step(1, '0, '0, 1);
    step(1, 3'b110, {8'hA5, 8'hA4, 8'h00}, 1);
    repeat (3) step(1, '0, '0, 1);
    for (int k = 0; k < 7; k++) step(1, 3'b001, {16'h0, W'(8'hB0 + k)}, 0);
    for (int k = 0; k < 8; k++) step(1, 3'b110, {W'(8'hD0 + k), W'(8'hC0 + k), 8'h00}, 1);
    repeat (4) step(1, '0, '0, 1);
    step(1, '1, {8'h12, 8'h11, 8'h10}, 0);
    step(1, 3'b001, {8'h00, 8'h00, 8'h13}, 0);
    step(0, '0, '0, 1);
    step(1, '1, {8'h22, 8'h21, 8'h20}, 1);
    repeat (3) step(1, '0, '0, 1);
    for (int c = 0; c < 3000; c++) begin
      case ((c / 300) % 4)
        0: begin vp = 80; rp = 90; end
        1: begin vp = 90; rp = 20; end
        2: begin vp = 30; rp = 100; end
        default: begin vp = 60; rp = 60; end
      endcase
      for (int i = 0; i < L; i++) vs[i] = $urandom_range(0, 99) < vp;
      ds = (L*W)'($urandom);
      ru = $urandom_range(0, 99) < rp;
      rst_n = $urandom_range(0, 249) != 0;
      step(rst_n, vs, ds, ru);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
